// File: rtl/tinyqv_uart_tx_if.sv
// CPU peripheral bus bundle between the TinyQV core and the UART transmitter.
interface tinyqv_uart_tx_if;
    logic [27:0] data_addr;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic [31:0] data_in;

    modport master (
        output data_addr,
        output data_write_n,
        output data_read_n,
        output data_out,
        input  data_ready,
        input  data_in
    );

    modport slave (
        input  data_addr,
        input  data_write_n,
        input  data_read_n,
        input  data_out,
        output data_ready,
        output data_in
    );
endinterface

// File: rtl/tinyqv_uart_tx.sv
// TinyQV UART transmitter: 4-entry TX FIFO, programmable bit divider,
// 8N1 framing, level interrupt when everything has drained.
module tinyqv_uart_tx #(
    parameter logic [27:0] BASE_ADDR       = 28'h8000000,
    parameter logic [15:0] DEFAULT_DIVIDER = 16'd103
) (
    input  logic                    clk,
    input  logic                    rst,
    tinyqv_uart_tx_if.slave         bus,
    output logic                    uart_txd,
    output logic                    tx_irq
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic [7:0]  fifo_mem_q [4];
    logic [1:0]  rd_ptr_q, wr_ptr_q;
    logic [2:0]  count_q;
    logic [15:0] divider_q;
    logic [1:0]  guard_q;
    logic        ready_q;
    logic [31:0] rdata_q;
    tx_state_t   state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        txd_q;
    logic        irq_q;

    logic        fifo_full, fifo_empty, busy, bit_end, pop;
    logic        sel, is_write, tx_write, accept, push;
    logic [3:0]  offset;
    logic [31:0] rdata_d;
    logic        unused_bits;

    assign unused_bits = &{1'b0, bus.data_out[31:16]};

    // Bus decode, acceptance and FIFO status
    always_comb begin
        fifo_full  = (count_q == 3'd4);
        fifo_empty = (count_q == 3'd0);
        busy       = (state_q != IDLE);
        bit_end    = (cnt_q == '0);
        pop        = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
        offset     = bus.data_addr[3:0];
        is_write   = (bus.data_write_n != 2'b11);
        sel        = (bus.data_addr[27:4] == BASE_ADDR[27:4]) &&
                     (is_write || (bus.data_read_n != 2'b11));
        tx_write   = is_write && (offset == 4'h0);
        // A full FIFO still takes the push when the shifter pops in the same cycle
        accept     = sel && (guard_q == 2'd0) && !(tx_write && fifo_full && !pop);
        push       = accept && tx_write;
        rdata_d    = '0;
        if (!is_write) begin
            case (offset)
                4'h4:    rdata_d = {29'b0, busy, fifo_empty, fifo_full};
                4'h8:    rdata_d = {16'b0, divider_q};
                default: rdata_d = '0;
            endcase
        end
    end

    // Acknowledge pulse, registered read data and post-ack request guard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            guard_q <= '0;
        end else begin
            ready_q <= accept;
            rdata_q <= accept ? rdata_d : '0;
            if (accept)
                guard_q <= 2'd2;
            else if (guard_q != 2'd0)
                guard_q <= guard_q - 2'd1;
        end
    end

    // Divider register; byte writes touch only the low byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divider_q <= DEFAULT_DIVIDER;
        end else if (accept && is_write && (offset == 4'h8)) begin
            case (bus.data_write_n)
                2'b00:   divider_q[7:0] <= bus.data_out[7:0];
                2'b01,
                2'b10:   divider_q <= bus.data_out[15:0];
                default: divider_q <= divider_q;
            endcase
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= bus.data_out[7:0];
    end

    // Transmit state machine; divider is sampled at every bit start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q <= fifo_mem_q[rd_ptr_q];
                        txd_q   <= 1'b0;
                        cnt_q   <= divider_q;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        txd_q     <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= '0;
                        cnt_q     <= divider_q;
                        state_q   <= DATA;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= divider_q;
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            txd_q     <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift_q <= fifo_mem_q[rd_ptr_q];
                            txd_q   <= 1'b0;
                            cnt_q   <= divider_q;
                            state_q <= START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Drained interrupt, registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= fifo_empty && (state_q == IDLE);
    end

    assign bus.data_ready = ready_q;
    assign bus.data_in    = rdata_q;
    assign uart_txd       = txd_q;
    assign tx_irq         = irq_q;

endmodule
